// File: rtl/tut4_verilog_regincr_reg_incr_pipe.sv
// Elastic NSTAGES-deep registered incrementer: every stage adds INC, with val/rdy handshake and bubble collapsing.
// Define TUT4_VERILOG_REGINCR_SATURATE_EN to make each stage saturate at all-ones instead of wrapping.
module tut4_verilog_regincr_reg_incr_pipe #(
  parameter int unsigned W       = 8,
  parameter int unsigned NSTAGES = 2,
  parameter int unsigned INC     = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [W-1:0]                   in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [W-1:0]                   out_msg,
  output logic [$clog2(NSTAGES+1)-1:0]   count
);

  localparam int         N     = int'(NSTAGES);
  localparam int         CW    = $clog2(NSTAGES + 1);
  localparam logic [W:0] INC_X = (W+1)'(INC);

  // The carry out of the widened sum flags overflow past all-ones.
  function automatic logic [W-1:0] incr(input logic [W-1:0] x);
    logic [W:0] sum;
    sum = {1'b0, x} + INC_X;
`ifdef TUT4_VERILOG_REGINCR_SATURATE_EN
    return sum[W] ? '1 : sum[W-1:0];
`else
    return sum[W-1:0];
`endif
  endfunction

  logic [N-1:0]   val;
  logic [W-1:0]   data    [N];
  logic [N-1:0]   val_up;
  logic [W-1:0]   data_up [N];
  logic [N:0]     go;
  logic           in_xfer;
  logic           out_xfer;

  // go[i] is true when downstream can move or any stage from i onward is empty,
  // which is the unrolled form of go[i] = !val[i] || go[i+1].
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    go = '0;
    for (int i = 0; i <= N; i++) begin
      go[i] = out_rdy;
      for (int j = i; j < N; j++) begin
        if (!val[j]) go[i] = 1'b1;
      end
    end
  end

  always_comb begin
    val_up     = '0;
    val_up[0]  = in_val;
    data_up[0] = in_msg;
    for (int i = 1; i < N; i++) begin
      val_up[i]  = val[i-1];
      data_up[i] = data[i-1];
    end
  end

  assign in_rdy   = go[0];
  assign out_val  = val[N-1];
  assign out_msg  = data[N-1];
  assign in_xfer  = in_val && go[0];
  assign out_xfer = out_val && out_rdy;

  // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge value of its upstream.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      val <= '0;
      // NOTE: the data array is reset too, because out_msg must read 0 straight after reset.
      for (int i = 0; i < N; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (go[i]) begin
          val[i]  <= val_up[i];
          data[i] <= incr(data_up[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_tut4_verilog_regincr_reg_incr_pipe.sv
// Bench for the elastic incrementer: a 2-stage and a 3-stage instance share stimulus and are
// checked every cycle against a message-level queue model, plus literal expectations.
module tb_tut4_verilog_regincr_reg_incr_pipe;

  localparam int W   = 8;
  localparam int INC = 1;
  localparam int NS0 = 2;
  localparam int NS1 = 3;
  localparam int CW0 = $clog2(NS0 + 1);
  localparam int CW1 = $clog2(NS1 + 1);

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_val  = 1'b0;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   in_msg  = '0;

  logic           in_rdy0, out_val0, in_rdy1, out_val1;
  logic [W-1:0]   out_msg0, out_msg1;
  logic [CW0-1:0] count0;
  logic [CW1-1:0] count1;

  always #5 clk = ~clk;

  tut4_verilog_regincr_reg_incr_pipe #(.W(W), .NSTAGES(NS0), .INC(INC)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy0), .in_msg(in_msg),
    .out_val(out_val0), .out_rdy(out_rdy), .out_msg(out_msg0), .count(count0)
  );

  tut4_verilog_regincr_reg_incr_pipe #(.W(W), .NSTAGES(NS1), .INC(INC)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy1), .in_msg(in_msg),
    .out_val(out_val1), .out_rdy(out_rdy), .out_msg(out_msg1), .count(count1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference transfer function: apply the per-stage rule 'times' times with plain integer arithmetic.
  function automatic logic [W-1:0] f_model(input logic [W-1:0] x, input int times);
    int unsigned v;
    v = x;
    for (int k = 0; k < times; k++) begin
`ifdef TUT4_VERILOG_REGINCR_SATURATE_EN
      v = (v + INC > 2**W - 1) ? 2**W - 1 : v + INC;
`else
      v = (v + INC) % (2**W);
`endif
    end
    return W'(v);
  endfunction

  // Model: per instance, an ordered list of in-flight messages (oldest first) with their stage position.
  logic [W-1:0] m_val [2][4];
  int           m_pos [2][4];
  int           m_n   [2];
  bit           model_live = 1'b0;

  function automatic int depth(input int d);
    return (d == 0) ? NS0 : NS1;
  endfunction

  task automatic model_edge(input int d);
    int  ns;
    int  lim;
    bit  accept;
    ns     = depth(d);
    accept = in_val && (out_rdy || m_n[d] < ns);
    if (!reset_n) begin
      m_n[d] = 0;
      return;
    end
    if (m_n[d] > 0 && m_pos[d][0] == ns - 1 && out_rdy) begin
      for (int k = 1; k < m_n[d]; k++) begin
        m_val[d][k-1] = m_val[d][k];
        m_pos[d][k-1] = m_pos[d][k];
      end
      m_n[d]--;
    end
    lim = ns;
    for (int k = 0; k < m_n[d]; k++) begin
      if (m_pos[d][k] + 1 < lim) m_pos[d][k]++;
      lim = m_pos[d][k];
    end
    if (accept) begin
      m_val[d][m_n[d]] = in_msg;
      m_pos[d][m_n[d]] = 0;
      m_n[d]++;
    end
  endtask

  task automatic compare_all();
    bit exp_val0, exp_val1;
    exp_val0 = (m_n[0] > 0) && (m_pos[0][0] == NS0 - 1);
    exp_val1 = (m_n[1] > 0) && (m_pos[1][0] == NS1 - 1);
    check("d0.in_rdy",  32'(in_rdy0),   32'(out_rdy || m_n[0] < NS0));
    check("d0.out_val", 32'(out_val0),  32'(exp_val0));
    check("d0.count",   32'(count0),    32'(m_n[0]));
    if (exp_val0) check("d0.out_msg", 32'(out_msg0), 32'(f_model(m_val[0][0], NS0)));
    check("d1.in_rdy",  32'(in_rdy1),   32'(out_rdy || m_n[1] < NS1));
    check("d1.out_val", 32'(out_val1),  32'(exp_val1));
    check("d1.count",   32'(count1),    32'(m_n[1]));
    if (exp_val1) check("d1.out_msg", 32'(out_msg1), 32'(f_model(m_val[1][0], NS1)));
  endtask

  // Log of instance-0 output transfers as seen on the DUT pins.
  logic [W-1:0] log_msg [256];
  int           log_cyc [256];
  int           n_log     = 0;
  int           cyc       = 0;
  int           peak0     = 0;
  bit           pre_rdy0  = 1'b0;
  bit           pre_rdy1  = 1'b0;

  // One cycle: drive inputs, compare against the model before the edge, then advance the model.
  task automatic step(input bit rn, input bit iv, input logic [W-1:0] im, input bit ordy);
    reset_n = rn;
    in_val  = iv;
    in_msg  = im;
    out_rdy = ordy;
    #1;
    if (model_live) compare_all();
    pre_rdy0 = in_rdy0;
    pre_rdy1 = in_rdy1;
    if (int'(count0) > peak0) peak0 = int'(count0);
    if (reset_n && out_val0 && out_rdy && n_log < 256) begin
      log_msg[n_log] = out_msg0;
      log_cyc[n_log] = cyc;
      n_log++;
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    if (!rn) model_live = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin : stim
    int            base;
    int            c0;
    int            idx;
    logic [W-1:0]  bp_msg [4];
    m_n[0] = 0;
    m_n[1] = 0;
    @(posedge clk);
    #1;

    // Reset held for two cycles.
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("reset.out_val", 32'(out_val0), 32'h0);
    check("reset.out_msg", 32'(out_msg0), 32'h0);
    check("reset.count",   32'(count0),   32'h0);
    check("reset.in_rdy",  32'(in_rdy0),  32'h1);
    check("reset.out_msg1", 32'(out_msg1), 32'h0);

    // Back-to-back streaming.
    base  = n_log;
    peak0 = 0;
    c0    = cyc;
    step(1'b1, 1'b1, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h05, 1'b1);
    step(1'b1, 1'b1, 8'h10, 1'b1);
    drain(4);
    check("stream.out0",    32'(log_msg[base]),     32'h02);
    check("stream.out1",    32'(log_msg[base + 1]), 32'h07);
    check("stream.out2",    32'(log_msg[base + 2]), 32'h12);
    check("stream.latency", 32'(log_cyc[base] - c0), 32'd2);
    check("stream.back2back", 32'(log_cyc[base + 2] - log_cyc[base]), 32'd2);
    check("stream.peak",    32'(peak0), 32'd2);

    // Wrap-around or saturation at the top of the range.
    base = n_log;
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    drain(4);
`ifdef TUT4_VERILOG_REGINCR_SATURATE_EN
    check("wrap.out", 32'(log_msg[base]), 32'hFF);
`else
    check("wrap.out", 32'(log_msg[base]), 32'h01);
`endif

    // Back-pressure: offer four messages with out_rdy low, then release.
    base = n_log;
    for (int k = 0; k < 4; k++) bp_msg[k] = W'(8'h20 + k);
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, bp_msg[idx], 1'b0);
      if (pre_rdy0) idx++;
    end
    check("bp.accepted", 32'(idx),     32'd2);
    check("bp.in_rdy",   32'(in_rdy0), 32'h0);
    check("bp.count",    32'(count0),  32'd2);
    for (int k = 0; k < 20 && idx < 4; k++) begin
      step(1'b1, 1'b1, bp_msg[idx], 1'b1);
      if (pre_rdy0) idx++;
    end
    drain(5);
    check("bp.n_out", 32'(n_log - base), 32'd4);
    for (int k = 0; k < 4; k++) check("bp.order", 32'(log_msg[base + k]), 32'(8'h22 + k));

    // Bubble collapse on the 3-stage instance: last stage stalled, stage 1 empty.
    step(1'b1, 1'b1, 8'h40, 1'b0);
    step(1'b1, 1'b0, '0,    1'b0);
    step(1'b1, 1'b0, '0,    1'b0);
    check("bubble.count_before", 32'(count1),   32'd1);
    check("bubble.out_val",      32'(out_val1), 32'h1);
    check("bubble.msg_before",   32'(out_msg1), 32'h43);
    step(1'b1, 1'b1, 8'h50, 1'b0);
    check("bubble.accepted",     32'(pre_rdy1), 32'h1);
    check("bubble.count_after",  32'(count1),   32'd2);
    check("bubble.msg_after",    32'(out_msg1), 32'h43);
    drain(6);

    // Reset pulse with two messages in flight and in_val high.
    step(1'b1, 1'b1, 8'h60, 1'b0);
    step(1'b1, 1'b1, 8'h61, 1'b0);
    check("midrst.count_before", 32'(count0), 32'd2);
    step(1'b0, 1'b1, 8'h62, 1'b0);
    check("midrst.count",   32'(count0),   32'd0);
    check("midrst.out_val", 32'(out_val0), 32'h0);
    base = n_log;
    drain(6);
    check("midrst.no_output", 32'(n_log - base), 32'd0);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
           W'($urandom), $urandom_range(0, 9) < 7);
    end
    drain(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
